// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle HI/LO unit in EX: launches MULT/DIV, stalls the front of the pipe
// for the fixed latency, holds the result until the instruction advances, cancels on flush.
module muldiv_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 2,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic startE,
    input  logic is_divE,
    input  logic signedE,
    input  logic stallE,
    input  logic flushE,
    output logic mdu_start,
    output logic mdu_is_div,
    output logic mdu_signed,
    output logic mdu_cancel,
    output logic stall_req,
    output logic result_valid,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             is_div_next, signed_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mdu_is_div <= 1'b0;
            mdu_signed <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            mdu_is_div <= is_div_next;
            mdu_signed <= signed_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        is_div_next  = mdu_is_div;
        signed_next  = mdu_signed;
        mdu_start    = 1'b0;
        mdu_cancel   = 1'b0;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                // Stall is raised in the launch cycle itself so the instruction stays in EX.
                if (startE && !flushE) begin
                    mdu_start   = 1'b1;
                    stall_req   = 1'b1;
                    is_div_next = is_divE;
                    signed_next = signedE;
                    cnt_next    = is_divE ? DIV_LOAD : MUL_LOAD;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (flushE) begin
                    mdu_cancel = 1'b1;
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // Held while another source stalls EX; a stalled startE is the same instruction.
                result_valid = !flushE;
                if (!stallE || flushE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed pipeline scenarios plus randomized traffic, all
// checked cycle by cycle against a timestamp-based model of one in-flight HI/LO operation.
module tb_muldiv_ctrl;

    localparam int DIV_N = 32;
    localparam int MUL_N = 2;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst, startE, is_divE, signedE, stallE, flushE;
    logic mdu_start, mdu_is_div, mdu_signed, mdu_cancel, stall_req, result_valid, busy;

    always #5 clk = ~clk;

    muldiv_ctrl #(.DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .startE(startE), .is_divE(is_divE), .signedE(signedE),
        .stallE(stallE), .flushE(flushE), .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
        .mdu_signed(mdu_signed), .mdu_cancel(mdu_cancel), .stall_req(stall_req),
        .result_valid(result_valid), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, described by its age in cycles since launch.
    bit m_known  = 1'b0;
    bit m_active = 1'b0;
    int m_age    = 0;
    int m_lat    = 0;
    bit m_div    = 1'b0;
    bit m_sgn    = 1'b0;

    // One pipeline cycle: drive inputs after negedge, check outputs, then advance the model.
    task automatic step(input bit s, input bit d, input bit g, input bit f, input bit x, input bit r);
        bit in_busy, in_done, e_start, e_cancel, e_stall, e_valid;
        @(negedge clk);
        in_busy  = m_active && (m_age <= m_lat);
        in_done  = m_active && (m_age > m_lat);
        e_start  = !m_active && s && !f;
        e_cancel = in_busy && f;
        e_stall  = e_start || in_busy;
        e_valid  = in_done && !f;
        rst = r; startE = s; is_divE = d; signedE = g; flushE = f;
        stallE = x | e_stall;
        #2;
        if (m_known) begin
            check("mdu_start",    int'(mdu_start),    int'(e_start));
            check("mdu_cancel",   int'(mdu_cancel),   int'(e_cancel));
            check("stall_req",    int'(stall_req),    int'(e_stall));
            check("result_valid", int'(result_valid), int'(e_valid));
            check("busy",         int'(busy),         int'(m_active));
            check("mdu_is_div",   int'(mdu_is_div),   int'(m_div));
            check("mdu_signed",   int'(mdu_signed),   int'(m_sgn));
        end
        if (r) begin
            m_active = 1'b0; m_div = 1'b0; m_sgn = 1'b0; m_known = 1'b1;
        end else if (!m_active) begin
            if (s && !f) begin
                m_active = 1'b1; m_age = 1; m_lat = d ? DIV_N : MUL_N;
                m_div = d; m_sgn = g;
            end
        end else if (in_busy && f) begin
            m_active = 1'b0;
        end else if (in_done && (!stallE || f)) begin
            m_active = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    typedef struct {
        int starts, valid_first, valid_last, stall_last, cancel_at, writes, div_at1, sgn_at1;
    } op_res_t;

    // Holds one mult/div instruction in EX from cycle 0 until it leaves, is killed, or reset hits.
    task automatic op(input bit d, input bit g, input int flush_at, input int ext_hold,
                      input int rst_at, output op_res_t res);
        bit ended = 1'b0;
        res = '{0, -1, -1, -1, -1, 0, -1, -1};
        for (int c = 0; c < 60 && !ended; c++) begin
            step(1'b1, d, g, c == flush_at, c < ext_hold, c == rst_at);
            if (mdu_start) res.starts++;
            if (result_valid) begin
                if (res.valid_first < 0) res.valid_first = c;
                res.valid_last = c;
                if (!stallE) res.writes++;
            end
            if (stall_req)  res.stall_last = c;
            if (mdu_cancel) res.cancel_at  = c;
            if (c == 1) begin res.div_at1 = int'(mdu_is_div); res.sgn_at1 = int'(mdu_signed); end
            if (!m_active) ended = 1'b1;
        end
        if (!ended) check("op_timeout", 1, 0);
    endtask

    op_res_t r;

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_busy", int'(busy), 0);

        // Signed DIV with stallE = stall_req only.
        op(1'b1, 1'b1, -1, 0, -1, r);
        check("div_starts", r.starts, 1);
        check("div_stall_last", r.stall_last, DIV_N);
        check("div_valid_first", r.valid_first, DIV_N + 1);
        check("div_writes", r.writes, 1);
        check("div_latched", r.div_at1, 1);
        // Back-to-back MULTU launches on the very next cycle.
        op(1'b0, 1'b0, -1, 0, -1, r);
        check("multu_starts", r.starts, 1);
        check("multu_is_div", r.div_at1, 0);
        check("multu_signed", r.sgn_at1, 0);
        check("multu_stall_last", r.stall_last, MUL_N);
        check("multu_valid_first", r.valid_first, MUL_N + 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("multu_idle_after", int'(busy), 0);

        // DIV flushed at cycle 10.
        op(1'b1, 1'b1, 10, 0, -1, r);
        check("flush_cancel_at", r.cancel_at, 10);
        check("flush_no_valid", r.valid_first, -1);
        check("flush_stall_last", r.stall_last, 10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_idle_stall", int'(stall_req), 0);

        // MULT finishing under an external stall held through cycle 5.
        op(1'b0, 1'b1, -1, 6, -1, r);
        check("hold_valid_first", r.valid_first, MUL_N + 1);
        check("hold_valid_last", r.valid_last, 6);
        check("hold_writes", r.writes, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_idle_after", int'(busy), 0);

        // Reset at cycle 15 of a DIV, then a fresh DIV.
        op(1'b1, 1'b1, -1, 0, 15, r);
        check("rst_no_cancel", r.cancel_at, -1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_outputs", int'({mdu_start, mdu_cancel, stall_req, result_valid, busy,
                                   mdu_is_div, mdu_signed}), 0);
        op(1'b1, 1'b0, -1, 0, -1, r);
        check("rst_relaunch_start", r.starts, 1);
        check("rst_relaunch_valid", r.valid_first, DIV_N + 1);

        // Randomized traffic with flushes, external stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) != 0, ($urandom % 4) == 0, $urandom % 2,
                 ($urandom % 20) == 0, ($urandom % 4) == 0, ($urandom % 300) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
